crossbar_shift_up: RTL and testbench

CROSSBAR_SHIFT_UP -- requirements
Module: crossbarShiftUp

---
 rtl/crossbar_shift_up.sv | 90 +++++++++
 tb/tb_crossbar_shift_up.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_shift_up.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crossbar_shift_up: phased upward lane rotation, one phase per load.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module crossbar_shift_up #(
  parameter int LANES  = 16,
  parameter int WIDTH  = 32,
  parameter int STEP   = 2,
  parameter int PHASES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_clk_en,
  input  logic                         io_start,
  input  logic                         io_flush,
  input  logic [LANES*WIDTH-1:0]       io_in,
  output logic [LANES*WIDTH-1:0]       io_out,
  output logic                         io_out_valid,
  output logic [$clog2(PHASES+1)-1:0]  io_phase,
  output logic                         io_done,
  output logic                         io_start_next_stage
);

  localparam int PW = $clog2(PHASES + 1);
  localparam int LW = $clog2(LANES);
  // LANES is a power of two, so the rotation is exact modulo 2**LW arithmetic.
  localparam logic [LW-1:0] STEP_MOD = LW'(STEP % LANES);

  logic [PW-1:0]          phase_q, phase_d;
  logic [LANES*WIDTH-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   sns_q, sns_d;

  logic                   done;
  logic                   fire;
  logic [LW-1:0]          rot;
  logic [WIDTH-1:0]       in_lane [LANES];
  logic [LANES*WIDTH-1:0] rotated;

  assign done = (phase_q == PW'(PHASES));
  assign fire = io_clk_en & io_start & ~done & ~io_flush;
  assign rot  = STEP_MOD * LW'(phase_q);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LW-1:0] src;
    assign in_lane[i]                 = io_in[i*WIDTH +: WIDTH];
    assign src                        = LW'(i) + rot;
    assign rotated[i*WIDTH +: WIDTH]  = in_lane[src];
  end

  always_comb begin
    phase_d = phase_q;
    out_d   = out_q;
    sns_d   = sns_q;
    valid_d = fire;
    if (io_clk_en) begin
      if (io_flush) begin
        phase_d = '0;
        sns_d   = 1'b0;
      end else if (fire) begin
        out_d   = rotated;
        phase_d = phase_q + PW'(1);
        sns_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      sns_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      sns_q   <= sns_d;
    end
  end

  assign io_out              = out_q;
  assign io_out_valid        = valid_q;
  assign io_phase            = phase_q;
  assign io_done             = done;
  assign io_start_next_stage = sns_q;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_shift_up.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crossbar_shift_up: vector table, corner sequences and random model.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_crossbar_shift_up;

  localparam int LANES  = 16;
  localparam int WIDTH  = 32;
  localparam int STEP   = 2;
  localparam int PHASES = 4;
  localparam int PW     = $clog2(PHASES + 1);

  logic                   clk = 1'b0;
  logic                   reset, io_clk_en, io_start, io_flush;
  logic [LANES*WIDTH-1:0] io_in;
  logic [LANES*WIDTH-1:0] io_out;
  logic                   io_out_valid, io_done, io_start_next_stage;
  logic [PW-1:0]          io_phase;

  logic [31:0]            p1_out;
  logic                   p1_valid, p1_done, p1_sns;
  logic [0:0]             p1_phase;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crossbar_shift_up #(.LANES(LANES), .WIDTH(WIDTH), .STEP(STEP), .PHASES(PHASES)) dut (
    .clk(clk), .reset(reset), .io_clk_en(io_clk_en), .io_start(io_start),
    .io_flush(io_flush), .io_in(io_in), .io_out(io_out), .io_out_valid(io_out_valid),
    .io_phase(io_phase), .io_done(io_done), .io_start_next_stage(io_start_next_stage)
  );

  crossbar_shift_up #(.LANES(4), .WIDTH(8), .STEP(3), .PHASES(1)) dut_p1 (
    .clk(clk), .reset(reset), .io_clk_en(io_clk_en), .io_start(io_start),
    .io_flush(io_flush), .io_in(io_in[31:0]), .io_out(p1_out), .io_out_valid(p1_valid),
    .io_phase(p1_phase), .io_done(p1_done), .io_start_next_stage(p1_sns)
  );

  typedef struct {
    bit rst, en, start, flush;
    int pat;
    int ph;
    bit vl, dn, sn;
    int l0, l15;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LANES*WIDTH-1:0] act,
                         input logic [LANES*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input bit rst, en, st, fl, input int pat, ph, input bit vl, dn, sn,
                     input int l0, l15);
    vec_t v;
    v.rst = rst; v.en = en; v.start = st; v.flush = fl; v.pat = pat;
    v.ph = ph; v.vl = vl; v.dn = dn; v.sn = sn; v.l0 = l0; v.l15 = l15;
    vecs.push_back(v);
  endtask

  function automatic logic [LANES*WIDTH-1:0] pattern(input int pat);
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = (pat != 0) ? 32'(k + 100) : 32'(k);
    return r;
  endfunction

  // Reference: lane rules and phase bookkeeping expressed directly as arithmetic.
  int               m_phase;
  bit               m_valid, m_sns;
  logic [WIDTH-1:0] m_out [LANES];

  function automatic logic [LANES*WIDTH-1:0] m_packed();
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = m_out[i];
    return r;
  endfunction

  task automatic model_edge();
    bit f;
    f = io_clk_en && io_start && (m_phase != PHASES) && !io_flush;
    if (reset) begin
      m_phase = 0; m_valid = 0; m_sns = 0;
      for (int i = 0; i < LANES; i++) m_out[i] = '0;
    end else begin
      m_valid = f;
      if (io_clk_en && io_flush) begin
        m_phase = 0; m_sns = 0;
      end else if (f) begin
        for (int i = 0; i < LANES; i++)
          m_out[i] = io_in[((i + STEP * m_phase) % LANES) * WIDTH +: WIDTH];
        m_phase = m_phase + 1;
        m_sns = 1;
      end
    end
  endtask

  initial begin
    logic [LANES*WIDTH-1:0] orig, down, exp_v;
    logic [31:0]            p1_in;
    reset = 1'b1; io_clk_en = 1'b0; io_start = 1'b0; io_flush = 1'b0; io_in = '0;

    //   rst en st fl pat  ph vl dn sn  l0 l15
    add(1, 1, 0, 0, 0,   0, 0, 0, 0,  0, 0);
    add(0, 1, 1, 0, 0,   1, 1, 0, 1,  0, 15);
    add(0, 1, 1, 0, 0,   2, 1, 0, 1,  2, 1);
    add(0, 1, 1, 0, 0,   3, 1, 0, 1,  4, 3);
    add(0, 1, 1, 0, 0,   4, 1, 1, 1,  6, 5);
    add(0, 1, 1, 0, 1,   4, 0, 1, 1,  6, 5);
    add(0, 1, 0, 0, 1,   4, 0, 1, 1,  6, 5);
    add(0, 0, 0, 1, 0,   4, 0, 1, 1,  6, 5);
    add(0, 1, 0, 1, 0,   0, 0, 0, 0,  6, 5);
    add(0, 1, 1, 0, 0,   1, 1, 0, 1,  0, 15);
    add(0, 1, 1, 0, 0,   2, 1, 0, 1,  2, 1);
    add(0, 0, 1, 0, 1,   2, 0, 0, 1,  2, 1);
    add(0, 0, 1, 0, 1,   2, 0, 0, 1,  2, 1);
    add(0, 0, 1, 0, 1,   2, 0, 0, 1,  2, 1);
    add(0, 1, 1, 0, 0,   3, 1, 0, 1,  4, 3);
    add(0, 1, 0, 1, 0,   0, 0, 0, 0,  4, 3);
    add(0, 1, 1, 0, 0,   1, 1, 0, 1,  0, 15);
    add(0, 1, 1, 0, 0,   2, 1, 0, 1,  2, 1);
    add(0, 1, 1, 1, 0,   0, 0, 0, 0,  2, 1);
    add(0, 1, 1, 0, 0,   1, 1, 0, 1,  0, 15);
    add(0, 1, 1, 0, 0,   2, 1, 0, 1,  2, 1);
    add(0, 1, 1, 0, 0,   3, 1, 0, 1,  4, 3);
    add(1, 0, 1, 0, 0,   0, 0, 0, 0,  0, 0);
    add(0, 1, 1, 0, 0,   1, 1, 0, 1,  0, 15);
    add(0, 1, 0, 0, 0,   1, 0, 0, 1,  0, 15);

    for (int n = 0; n < vecs.size(); n++) begin
      reset = vecs[n].rst; io_clk_en = vecs[n].en; io_start = vecs[n].start;
      io_flush = vecs[n].flush; io_in = pattern(vecs[n].pat);
      step();
      chk($sformatf("vec%0d phase", n), 32'(io_phase), 32'(vecs[n].ph));
      chk($sformatf("vec%0d valid", n), 32'(io_out_valid), 32'(vecs[n].vl));
      chk($sformatf("vec%0d done", n), 32'(io_done), 32'(vecs[n].dn));
      chk($sformatf("vec%0d start_next", n), 32'(io_start_next_stage), 32'(vecs[n].sn));
      chk($sformatf("vec%0d lane0", n), io_out[0 +: WIDTH], 32'(vecs[n].l0));
      chk($sformatf("vec%0d lane15", n), io_out[15*WIDTH +: WIDTH], 32'(vecs[n].l15));
    end
    chk_vec("post_reset_identity", io_out, pattern(0));

    // Single-phase frame completes on its first load.
    reset = 1'b1; io_clk_en = 1'b1; io_start = 1'b0; io_flush = 1'b0;
    step();
    reset = 1'b0; io_start = 1'b1; io_in = '0; io_in[31:0] = $urandom; p1_in = io_in[31:0];
    step();
    chk("p1 done", 32'(p1_done), 32'd1);
    chk("p1 phase", 32'(p1_phase), 32'd1);
    chk("p1 valid", 32'(p1_valid), 32'd1);
    chk("p1 out", p1_out, p1_in);
    io_in[31:0] = ~p1_in;
    step();
    chk("p1 out held", p1_out, p1_in);
    chk("p1 valid low", 32'(p1_valid), 32'd0);

    // Round trip: downward shift by STEP*p then this block restores the original lanes.
    reset = 1'b1; io_start = 1'b0;
    step();
    reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < PHASES; p++) begin
        for (int k = 0; k < LANES; k++) orig[k*WIDTH +: WIDTH] = $urandom;
        for (int j = 0; j < LANES; j++)
          down[j*WIDTH +: WIDTH] = orig[(((j - STEP * p) % LANES + LANES) % LANES) * WIDTH +: WIDTH];
        io_in = down; io_start = 1'b1; io_flush = 1'b0;
        step();
        chk_vec($sformatf("roundtrip f%0d p%0d", f, p), io_out, orig);
      end
      io_start = 1'b0; io_flush = 1'b1;
      step();
      io_flush = 1'b0;
    end

    // Randomized run against the reference model.
    reset = 1'b1; io_clk_en = 1'b1; io_start = 1'b0; io_flush = 1'b0;
    model_edge();
    step();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      io_clk_en = ($urandom_range(0, 9) != 0);
      io_start  = ($urandom_range(0, 9) < 7);
      io_flush  = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < LANES; k++) io_in[k*WIDTH +: WIDTH] = $urandom;
      model_edge();
      step();
      exp_v = m_packed();
      chk_vec($sformatf("rnd%0d out", c), io_out, exp_v);
      chk($sformatf("rnd%0d phase", c), 32'(io_phase), 32'(m_phase));
      chk($sformatf("rnd%0d valid", c), 32'(io_out_valid), 32'(m_valid));
      chk($sformatf("rnd%0d done", c), 32'(io_done), 32'(m_phase == PHASES));
      chk($sformatf("rnd%0d start_next", c), 32'(io_start_next_stage), 32'(m_sns));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
